lsu_bus: RTL and testbench
==========================

LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles from request issue to response before an access fault is raised.
REQ-003 clk_i  in  1  clock; all state SHALL update on the rising edge.
REQ-004 n_rst_i  in  1  reset, asynchronous and active-low.
REQ-005 valid_i  in  1  EXU presents an access.
REQ-006 ready_o  out  1  LSU can accept an access.
REQ-007 is_load_i / is_store_i  in  1 each  access kind; store wins if both are set.
REQ-008 size_i  in  2  access size: 0 byte, 1 half, 2 word, 3 double.
REQ-009 unsigned_i  in  1  zero-extend load data.
REQ-010 addr_i / wdata_i  in  XLEN each  effective address / store data.
REQ-011 rd_wa_i  in  5  destination register.
REQ-012 bus_req_o, bus_we_o  out  1 each; bus_addr_o, bus_wdata_o  out  XLEN each; bus_be_o  out  XLEN/8.
REQ-013 bus_gnt_i, bus_rvalid_i, bus_err_i  in  1 each; bus_rdata_i  in  XLEN.
REQ-014 flush_i  in  1  pipeline flush from ctrl.
REQ-015 wb_valid_o, rd_we_o  out  1 each; rd_a_o  out  5; rd_wd_o  out  XLEN.
REQ-016 exc_valid_o  out  1; exc_cause_o  out  4; exc_tval_o  out  XLEN.
REQ-017 stall_req_o  out  1  request a pipeline stall.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DRAIN; ready_o=1 only in IDLE.
REQ-019 An access SHALL be accepted on valid_i & ready_o & (is_load_i | is_store_i); valid_i with neither kind set SHALL be ignored.
REQ-020 On accept, the LSU SHALL register addr, size, kind, unsigned flag, rd and lane-replicated store data.
REQ-021 Misalignment SHALL be addr[0]!=0 for half, addr[1:0]!=0 for word, addr[2:0]!=0 for double; size 3 at XLEN=32 SHALL be treated as misaligned.
REQ-022 A misaligned access SHALL raise no bus request, SHALL pulse exc_valid_o for one cycle in the cycle after accept (cause 4 for load, 6 for store, tval = addr), and SHALL leave the FSM in IDLE.
REQ-023 An aligned access SHALL enter REQ; bus_req_o=1 and bus_addr_o/bus_we_o/bus_be_o/bus_wdata_o SHALL stay stable until bus_gnt_i.
REQ-024 bus_be_o SHALL be little-endian: byte lane k is enabled for addr offset k; e.g. XLEN=32, half at offset 2 gives 4'b1100.
REQ-025 REQ & bus_gnt_i SHALL go to WAIT with bus_req_o=0 in the next cycle; only one access SHALL be outstanding.
REQ-026 WAIT & bus_rvalid_i & !bus_err_i SHALL go to IDLE and pulse wb_valid_o for one cycle in the next cycle.
REQ-027 Load data SHALL be taken from the lane at the registered offset and then sign- or zero-extended to XLEN.
REQ-028 rd_we_o SHALL equal wb_valid_o & load & (rd != 0); rd_wd_o SHALL be 0 for stores.
REQ-029 bus_rvalid_i & bus_err_i SHALL pulse exc_valid_o (cause 5 load / 7 store, tval = addr), SHALL NOT raise wb_valid_o, and SHALL return to IDLE.
REQ-030 A cycle counter SHALL run in REQ and WAIT; reaching TIMEOUT SHALL drop bus_req_o, raise an access fault per REQ-029, and return to IDLE.
REQ-031 flush_i in REQ before grant SHALL drop bus_req_o and go to IDLE; flush_i in the grant cycle or in WAIT SHALL go to DRAIN.
REQ-032 DRAIN SHALL wait for bus_rvalid_i or timeout, then return to IDLE with no writeback and no exception.
REQ-033 stall_req_o SHALL be 1 whenever the state is not IDLE.
REQ-034 flush_i in IDLE SHALL block acceptance for that cycle.

Reset
REQ-035 n_rst_i low SHALL force state IDLE, counter 0, and all outputs 0 except ready_o=1.
REQ-036 Reset asserted mid-access SHALL abandon the access with no writeback or exception after release.

Structure
REQ-037 Cause codes (4, 5, 6, 7), size encodings and the FSM state type SHALL live in the shared defines package.
REQ-038 Lane extraction and extension SHALL be one sub-module, lsu_load_align; everything else SHALL stay in lsu_bus.

Verification
REQ-039 LW addr 0x100, gnt after 2 cycles, rvalid after 3 cycles with rdata 0xDEADBEEF -> rd_wd_o=0xDEADBEEF, one wb pulse, stall_req_o high throughout.
REQ-040 LB addr 0x103 with rdata 0x80FF_FFFF -> rd_wd_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-041 SH addr 0x102, wdata 0x1234 -> bus_be_o=4'b1100, bus_wdata_o=0x12341234, no rd_we_o.
REQ-042 LW addr 0x101 -> no bus_req_o, exc cause 4, tval 0x101; SW addr 0x102 -> cause 6.
REQ-043 No rvalid for TIMEOUT cycles -> cause 5; rvalid with bus_err_i on a store -> cause 7.
REQ-044 flush_i in WAIT, then rvalid -> DRAIN then IDLE with no wb or exception; n_rst_i low in WAIT -> IDLE immediately.

Source files
------------

// File: rtl/lsu_bus_pkg.sv
// Shared definitions for the load/store bus unit: FSM states, access sizes
// and the exception cause codes it can raise.
package lsu_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } lsu_size_e;

    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_ACCESS      = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_ACCESS     = 4'd7;

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed lane out of a bus read word and sign- or zero-extends
// it to the full register width.
module lsu_load_align
    import lsu_bus_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]             rdata_i,
    input  logic [$clog2(XLEN/8)-1:0]   offset_i,
    input  lsu_size_e                   size_i,
    input  logic                        unsigned_i,
    output logic [XLEN-1:0]             data_o
);

    logic [XLEN-1:0] lane;

    // Shift the addressed byte down to lane 0, then extend by access size.
    always_comb begin
        lane   = rdata_i >> {offset_i, 3'b000};
        data_o = lane;
        case (size_i)
            SIZE_B:  data_o = unsigned_i ? XLEN'(lane[7:0])  : XLEN'($signed(lane[7:0]));
            SIZE_H:  data_o = unsigned_i ? XLEN'(lane[15:0]) : XLEN'($signed(lane[15:0]));
            SIZE_W:  data_o = unsigned_i ? XLEN'(lane[31:0]) : XLEN'($signed(lane[31:0]));
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit bus front end: accepts one access from EXU, checks
// alignment, runs a single-outstanding request/response bus transaction
// with timeout and flush handling, and returns writeback or exception.
module lsu_bus
    import lsu_bus_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                n_rst_i,
    // EXU request
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                is_load_i,
    input  logic                is_store_i,
    input  logic [1:0]          size_i,
    input  logic                unsigned_i,
    input  logic [XLEN-1:0]     addr_i,
    input  logic [XLEN-1:0]     wdata_i,
    input  logic [4:0]          rd_wa_i,
    // data bus
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [XLEN-1:0]     bus_addr_o,
    output logic [XLEN-1:0]     bus_wdata_o,
    output logic [XLEN/8-1:0]   bus_be_o,
    input  logic                bus_gnt_i,
    input  logic                bus_rvalid_i,
    input  logic                bus_err_i,
    input  logic [XLEN-1:0]     bus_rdata_i,
    // pipeline control
    input  logic                flush_i,
    output logic                wb_valid_o,
    output logic                rd_we_o,
    output logic [4:0]          rd_a_o,
    output logic [XLEN-1:0]     rd_wd_o,
    output logic                exc_valid_o,
    output logic [3:0]          exc_cause_o,
    output logic [XLEN-1:0]     exc_tval_o,
    output logic                stall_req_o
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 2) + 1;

    lsu_state_e         state_q, state_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [NB-1:0]      be_q, be_d;
    lsu_size_e          size_q, size_d;
    logic               store_q, store_d;
    logic               unsigned_q, unsigned_d;
    logic [4:0]         rd_q, rd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               wb_valid_q, wb_valid_d;
    logic               rd_we_q, rd_we_d;
    logic [4:0]         rd_a_q, rd_a_d;
    logic [XLEN-1:0]    rd_wd_q, rd_wd_d;
    logic               exc_valid_q, exc_valid_d;
    logic [3:0]         exc_cause_q, exc_cause_d;
    logic [XLEN-1:0]    exc_tval_q, exc_tval_d;

    logic               accept;
    logic               misaligned;
    logic               timed_out;
    logic [NB-1:0]      be_req;
    logic [XLEN-1:0]    wdata_rep;
    logic [XLEN-1:0]    load_data;

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .rdata_i    (bus_rdata_i),
        .offset_i   (addr_q[OW-1:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (load_data)
    );

    // Decode the incoming access: alignment, byte enables, replicated store data.
    always_comb begin
        int nbytes;
        int off;
        nbytes = 1 << size_i;
        off    = int'(addr_i[OW-1:0]);
        case (lsu_size_e'(size_i))
            SIZE_H:  misaligned = addr_i[0];
            SIZE_W:  misaligned = (addr_i[1:0] != 2'b00);
            SIZE_D:  misaligned = (XLEN == 32) || (addr_i[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
        for (int i = 0; i < NB; i++) begin
            be_req[i]            = (i >= off) && (i < off + nbytes);
            wdata_rep[i*8 +: 8]  = wdata_i[(i & (nbytes - 1))*8 +: 8];
        end
    end

    assign accept    = valid_i && (state_q == S_IDLE) && (is_load_i || is_store_i) && !flush_i;
    assign timed_out = (cnt_q >= CW'(TIMEOUT));

    // Next-state, access bookkeeping and one-cycle writeback/exception pulses.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        size_d      = size_q;
        store_d     = store_q;
        unsigned_d  = unsigned_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        wb_valid_d  = 1'b0;
        rd_we_d     = 1'b0;
        rd_a_d      = 5'd0;
        rd_wd_d     = '0;
        exc_valid_d = 1'b0;
        exc_cause_d = 4'd0;
        exc_tval_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d     = addr_i;
                    size_d     = lsu_size_e'(size_i);
                    store_d    = is_store_i;
                    unsigned_d = unsigned_i;
                    rd_d       = rd_wa_i;
                    wdata_d    = wdata_rep;
                    be_d       = be_req;
                    cnt_d      = '0;
                    if (misaligned) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = is_store_i ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
                        exc_tval_d  = addr_i;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (flush_i) begin
                    state_d = bus_gnt_i ? S_DRAIN : S_IDLE;
                end else if (bus_gnt_i) begin
                    state_d = S_WAIT;
                end else if (timed_out) begin
                    state_d     = S_IDLE;
                    exc_valid_d = 1'b1;
                    exc_cause_d = store_q ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
                    exc_tval_d  = addr_q;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_rvalid_i) begin
                    state_d = S_IDLE;
                    if (!flush_i) begin
                        if (bus_err_i) begin
                            exc_valid_d = 1'b1;
                            exc_cause_d = store_q ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
                            exc_tval_d  = addr_q;
                        end else begin
                            wb_valid_d = 1'b1;
                            rd_a_d     = rd_q;
                            rd_we_d    = !store_q && (rd_q != 5'd0);
                            rd_wd_d    = store_q ? '0 : load_data;
                        end
                    end
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end else if (timed_out) begin
                    state_d     = S_IDLE;
                    exc_valid_d = 1'b1;
                    exc_cause_d = store_q ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
                    exc_tval_d  = addr_q;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_rvalid_i || timed_out) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            size_q      <= SIZE_B;
            store_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            rd_q        <= 5'd0;
            cnt_q       <= '0;
            wb_valid_q  <= 1'b0;
            rd_we_q     <= 1'b0;
            rd_a_q      <= 5'd0;
            rd_wd_q     <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= 4'd0;
            exc_tval_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            size_q      <= size_d;
            store_q     <= store_d;
            unsigned_q  <= unsigned_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            wb_valid_q  <= wb_valid_d;
            rd_we_q     <= rd_we_d;
            rd_a_q      <= rd_a_d;
            rd_wd_q     <= rd_wd_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_tval_q  <= exc_tval_d;
        end
    end

    assign ready_o     = (state_q == S_IDLE);
    assign stall_req_o = (state_q != S_IDLE);
    assign bus_req_o   = (state_q == S_REQ);
    assign bus_we_o    = bus_req_o && store_q;
    assign bus_addr_o  = bus_req_o ? addr_q  : '0;
    assign bus_wdata_o = bus_req_o ? wdata_q : '0;
    assign bus_be_o    = bus_req_o ? be_q    : '0;
    assign wb_valid_o  = wb_valid_q;
    assign rd_we_o     = rd_we_q;
    assign rd_a_o      = rd_a_q;
    assign rd_wd_o     = rd_wd_q;
    assign exc_valid_o = exc_valid_q;
    assign exc_cause_o = exc_cause_q;
    assign exc_tval_o  = exc_tval_q;

endmodule

// File: tb/tb_lsu_bus.sv
// Directed testbench for lsu_bus with a response scoreboard: each access
// pushes its expected writeback/exception, a monitor pops and compares.
module tb_lsu_bus;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              valid = 1'b0;
    logic              is_load = 1'b0;
    logic              is_store = 1'b0;
    logic [1:0]        size = 2'd0;
    logic              uns = 1'b0;
    logic [XLEN-1:0]   addr = '0;
    logic [XLEN-1:0]   wdata = '0;
    logic [4:0]        rd_wa = 5'd0;
    logic              bus_gnt = 1'b0;
    logic              bus_rvalid = 1'b0;
    logic              bus_err = 1'b0;
    logic [XLEN-1:0]   bus_rdata = '0;
    logic              flush = 1'b0;

    logic              ready_o, bus_req_o, bus_we_o;
    logic [XLEN-1:0]   bus_addr_o, bus_wdata_o;
    logic [XLEN/8-1:0] bus_be_o;
    logic              wb_valid_o, rd_we_o, exc_valid_o, stall_req_o;
    logic [4:0]        rd_a_o;
    logic [XLEN-1:0]   rd_wd_o, exc_tval_o;
    logic [3:0]        exc_cause_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic            is_exc;
        logic [3:0]      cause;
        logic [XLEN-1:0] val;
        logic            we;
        logic [4:0]      rd;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    lsu_bus #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .n_rst_i      (n_rst),
        .valid_i      (valid),
        .ready_o      (ready_o),
        .is_load_i    (is_load),
        .is_store_i   (is_store),
        .size_i       (size),
        .unsigned_i   (uns),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .rd_wa_i      (rd_wa),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_be_o     (bus_be_o),
        .bus_gnt_i    (bus_gnt),
        .bus_rvalid_i (bus_rvalid),
        .bus_err_i    (bus_err),
        .bus_rdata_i  (bus_rdata),
        .flush_i      (flush),
        .wb_valid_o   (wb_valid_o),
        .rd_we_o      (rd_we_o),
        .rd_a_o       (rd_a_o),
        .rd_wd_o      (rd_wd_o),
        .exc_valid_o  (exc_valid_o),
        .exc_cause_o  (exc_cause_o),
        .exc_tval_o   (exc_tval_o),
        .stall_req_o  (stall_req_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every writeback or exception pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (n_rst && (wb_valid_o || exc_valid_o)) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {62'd0, wb_valid_o, exc_valid_o}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("resp_kind", {62'd0, wb_valid_o, exc_valid_o}, e.is_exc ? 64'd1 : 64'd2);
                if (e.is_exc) begin
                    check("exc_cause", exc_cause_o, e.cause);
                    check("exc_tval",  exc_tval_o,  e.val);
                end else begin
                    check("rd_wd", rd_wd_o, e.val);
                    check("rd_we", rd_we_o, e.we);
                    check("rd_a",  rd_a_o,  e.rd);
                end
            end
        end
    end

    task automatic push_wb(input logic [XLEN-1:0] v, input logic we, input logic [4:0] rd);
        exp_t x;
        x = '{is_exc: 1'b0, cause: 4'd0, val: v, we: we, rd: rd};
        sb.push_back(x);
    endtask

    task automatic push_exc(input logic [3:0] cause, input logic [XLEN-1:0] tval);
        exp_t x;
        x = '{is_exc: 1'b1, cause: cause, val: tval, we: 1'b0, rd: 5'd0};
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!ready_o && n < 100) begin
            tick();
            n++;
        end
        check("idle_reached", ready_o, 1'b1);
        tick();
        tick();
    endtask

    // Present one access for a single cycle; returns 1 unit after the accept edge.
    task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] wd, input logic [4:0] rd);
        tick();
        valid = 1'b1; is_load = !st; is_store = st; size = sz; uns = un;
        addr = a; wdata = wd; rd_wa = rd;
        tick();
        valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    // Grant after gnt_wait REQ cycles, respond in the rv_wait-th WAIT cycle.
    task automatic run_bus(input int gnt_wait, input int rv_wait,
                           input logic [XLEN-1:0] rdata, input logic err,
                           input logic [XLEN-1:0] a, input logic we,
                           input logic [XLEN/8-1:0] be, input logic [XLEN-1:0] wd);
        for (int i = 0; i <= gnt_wait; i++) begin
            check("bus_req",   bus_req_o,   1'b1);
            check("stall_req", stall_req_o, 1'b1);
            check("bus_addr",  bus_addr_o,  a);
            check("bus_we",    bus_we_o,    we);
            check("bus_be",    bus_be_o,    be);
            check("bus_wdata", bus_wdata_o, wd);
            if (i == gnt_wait) bus_gnt = 1'b1;
            tick();
        end
        bus_gnt = 1'b0;
        for (int i = 1; i <= rv_wait; i++) begin
            check("bus_req_wait", bus_req_o,   1'b0);
            check("stall_wait",   stall_req_o, 1'b1);
            if (i == rv_wait) begin
                bus_rvalid = 1'b1; bus_rdata = rdata; bus_err = err;
            end
            tick();
        end
        bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        check("ready_after", ready_o,     1'b1);
        check("stall_after", stall_req_o, 1'b0);
    endtask

    initial begin
        int n;
        // Reset state
        tick();
        check("rst_ready",  ready_o,     1'b1);
        check("rst_stall",  stall_req_o, 1'b0);
        check("rst_busreq", bus_req_o,   1'b0);
        check("rst_wb",     wb_valid_o,  1'b0);
        check("rst_exc",    exc_valid_o, 1'b0);
        check("rst_rdwd",   rd_wd_o,     32'd0);
        tick();
        n_rst = 1'b1;
        tick();

        // LW 0x100: grant after 2 cycles, data after 3
        push_wb(32'hDEADBEEF, 1'b1, 5'd10);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd10);
        run_bus(2, 3, 32'hDEADBEEF, 1'b0, 32'h100, 1'b0, 4'b1111, 32'h0);
        wait_idle();

        // LB / LBU at offset 3
        push_wb(32'hFFFFFF80, 1'b1, 5'd11);
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd11);
        run_bus(0, 1, 32'h80FFFFFF, 1'b0, 32'h103, 1'b0, 4'b1000, 32'h0);
        wait_idle();
        push_wb(32'h00000080, 1'b1, 5'd12);
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd12);
        run_bus(1, 2, 32'h80FFFFFF, 1'b0, 32'h103, 1'b0, 4'b1000, 32'h0);
        wait_idle();

        // LH at offset 2 (signed) and LHU to x0 (no register write)
        push_wb(32'hFFFF8001, 1'b1, 5'd13);
        issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 5'd13);
        run_bus(0, 1, 32'h80010000, 1'b0, 32'h102, 1'b0, 4'b1100, 32'h0);
        wait_idle();
        push_wb(32'h0000F00F, 1'b0, 5'd0);
        issue(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 5'd0);
        run_bus(0, 1, 32'h1234F00F, 1'b0, 32'h100, 1'b0, 4'b0011, 32'h0);
        wait_idle();

        // SH 0x102: replicated data, upper lanes, no register write
        push_wb(32'h0, 1'b0, 5'd5);
        issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234, 5'd5);
        run_bus(1, 1, 32'h0, 1'b0, 32'h102, 1'b1, 4'b1100, 32'h12341234);
        wait_idle();

        // Misaligned LW / SW: no bus request, exception next cycle
        push_exc(4'd4, 32'h101);
        issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd7);
        check("mis_ld_busreq", bus_req_o, 1'b0);
        check("mis_ld_ready",  ready_o,   1'b1);
        wait_idle();
        push_exc(4'd6, 32'h102);
        issue(1'b1, 2'd2, 1'b0, 32'h102, 32'h55, 5'd0);
        check("mis_st_busreq", bus_req_o, 1'b0);
        wait_idle();
        push_exc(4'd4, 32'h108);
        issue(1'b0, 2'd3, 1'b0, 32'h108, 32'h0, 5'd1);
        check("mis_ld_dbl_busreq", bus_req_o, 1'b0);
        wait_idle();

        // Timeout: granted, no response -> load access fault
        push_exc(4'd5, 32'h200);
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 5'd8);
        bus_gnt = 1'b1;
        n = 0;
        do begin
            tick();
            bus_gnt = 1'b0;
            n++;
        end while (!exc_valid_o && n < 60);
        check("timeout_cycles", n, TIMEOUT + 1);
        wait_idle();

        // Store with bus error -> store access fault
        push_exc(4'd7, 32'h300);
        issue(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D, 5'd0);
        run_bus(0, 2, 32'h0, 1'b1, 32'h300, 1'b1, 4'b1111, 32'hCAFEF00D);
        wait_idle();

        // Flush in WAIT -> DRAIN, then response discarded
        issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd3);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("drain_stall",  stall_req_o, 1'b1);
        check("drain_ready",  ready_o,     1'b0);
        check("drain_busreq", bus_req_o,   1'b0);
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'h55;
        tick();
        bus_rvalid = 1'b0; bus_rdata = '0;
        check("drain_done_ready", ready_o,     1'b1);
        check("drain_done_stall", stall_req_o, 1'b0);
        wait_idle();

        // Flush in REQ before grant -> straight back to IDLE
        issue(1'b1, 2'd2, 1'b0, 32'h404, 32'h1, 5'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("req_flush_ready",  ready_o,   1'b1);
        check("req_flush_busreq", bus_req_o, 1'b0);
        wait_idle();

        // Flush in IDLE blocks acceptance; valid with no kind is ignored
        tick();
        valid = 1'b1; is_load = 1'b1; size = 2'd2; addr = 32'h100; flush = 1'b1;
        tick();
        valid = 1'b0; is_load = 1'b0; flush = 1'b0;
        check("idle_flush_busreq", bus_req_o,   1'b0);
        check("idle_flush_stall",  stall_req_o, 1'b0);
        valid = 1'b1; addr = 32'h100;
        tick();
        valid = 1'b0;
        check("nokind_busreq", bus_req_o, 1'b0);
        wait_idle();

        // Reset in WAIT abandons the access
        issue(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 5'd4);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        n_rst = 1'b0;
        #1;
        check("rst_wait_ready",  ready_o,     1'b1);
        check("rst_wait_stall",  stall_req_o, 1'b0);
        check("rst_wait_busreq", bus_req_o,   1'b0);
        tick();
        n_rst = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h77;
        tick();
        bus_rvalid = 1'b0; bus_rdata = '0;
        check("rst_wait_idle", ready_o, 1'b1);
        wait_idle();

        tick();
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
